// File: rtl/keccak_nonce_scanner.sv
// Nonce feeder and target checker wrapped around the keccak512 pipeline.
// Define KECCAK_SCAN_HASHCNT_EN to add the hash_count output.
module keccak_nonce_scanner #(
    parameter int CORE_LATENCY = 50,
    parameter int NONCE_WIDTH  = 32,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     work_load,
    input  logic [511-NONCE_WIDTH:0] work_header,
    input  logic [NONCE_WIDTH-1:0]   start_nonce,
    input  logic [NONCE_WIDTH-1:0]   end_nonce,
    input  logic [63:0]              target,
    output logic [511:0]             core_data,
    input  logic [511:0]             core_hash,
    output logic                     busy,
    output logic                     done,
    output logic                     found_valid,
    input  logic                     found_ready,
    output logic [NONCE_WIDTH-1:0]   found_nonce,
`ifdef KECCAK_SCAN_HASHCNT_EN
    output logic [63:0]              hash_count,
`endif
    output logic [15:0]              drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CORE_LATENCY + 1) + 1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t                   state;
    logic [511-NONCE_WIDTH:0] header;
    logic [NONCE_WIDTH-1:0]   end_r;
    logic [NONCE_WIDTH-1:0]   cur_nonce;
    logic [63:0]              target_r;
    logic [CNT_W-1:0]         drain_cnt;

    logic                     core_tag_valid;
    logic [NONCE_WIDTH-1:0]   core_tag_nonce;
    logic [CORE_LATENCY-1:0]  tag_valid;
    logic [NONCE_WIDTH-1:0]   tag_nonce [CORE_LATENCY];

    logic                     hit;
    logic [NONCE_WIDTH-1:0]   hit_nonce;

    logic [NONCE_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W:0]           fifo_count;
    logic                     pop;
    logic                     push;
    logic                     hash_hi_unused;

    assign hash_hi_unused = ^core_hash[511:64];

    // core_tag sits beside core_data, mirroring the core's own input register;
    // the CORE_LATENCY-deep line behind it then lines up with core_hash.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            core_data      <= '0;
            header         <= '0;
            end_r          <= '0;
            target_r       <= '0;
            cur_nonce      <= '0;
            drain_cnt      <= '0;
            core_tag_valid <= 1'b0;
            core_tag_nonce <= '0;
        end else begin
            core_tag_valid <= 1'b0;
            if (work_load) begin
                header    <= work_header;
                end_r     <= end_nonce;
                target_r  <= target;
                cur_nonce <= start_nonce;
                state     <= SCAN;
                busy      <= 1'b1;
                done      <= 1'b0;
            end else begin
                unique case (state)
                    SCAN: begin
                        core_data      <= {header, cur_nonce};
                        core_tag_valid <= 1'b1;
                        core_tag_nonce <= cur_nonce;
                        if (cur_nonce == end_r) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            cur_nonce <= cur_nonce + NONCE_WIDTH'(1);
                        end
                    end
                    DRAIN: begin
                        if (drain_cnt == CNT_W'(CORE_LATENCY)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || work_load) begin
            tag_valid <= '0;
        end else begin
            tag_valid <= {tag_valid[CORE_LATENCY-2:0], core_tag_valid};
        end
    end

    always_ff @(posedge clk) begin
        tag_nonce[0] <= core_tag_nonce;
        for (int unsigned i = 1; i < CORE_LATENCY; i++) begin
            tag_nonce[i] <= tag_nonce[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit       <= 1'b0;
            hit_nonce <= '0;
        end else begin
            hit       <= tag_valid[CORE_LATENCY-1] && (core_hash[63:0] <= target_r);
            hit_nonce <= tag_nonce[CORE_LATENCY-1];
        end
    end

`ifdef KECCAK_SCAN_HASHCNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hash_count <= '0;
        end else if (tag_valid[CORE_LATENCY-1]) begin
            hash_count <= hash_count + 64'd1;
        end
    end
`endif

    assign found_valid = (fifo_count != '0);
    assign found_nonce = fifo_mem[rd_ptr];
    assign pop         = found_valid && found_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push        = hit && ((fifo_count != (PTR_W+1)'(FIFO_DEPTH)) || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            drop_count <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                fifo_mem[wr_ptr] <= hit_nonce;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
                default: ;
            endcase
            if (hit && !push && (drop_count != '1)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_keccak_nonce_scanner.sv
// Self-checking bench for keccak_nonce_scanner: delayed-hash core model plus
// a schedule-based reference of issue times, hit arrivals and FIFO occupancy.
module tb_keccak_nonce_scanner;

    localparam int L  = 50;
    localparam int NW = 32;
    localparam int FD = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         work_load = 1'b0;
    logic [479:0] work_header = '0;
    logic [31:0]  start_nonce = '0;
    logic [31:0]  end_nonce = '0;
    logic [63:0]  target = '0;
    logic [511:0] core_data;
    logic [511:0] core_hash;
    logic         busy;
    logic         done;
    logic         found_valid;
    logic         found_ready = 1'b0;
    logic [31:0]  found_nonce;
    logic [15:0]  drop_count;
`ifdef KECCAK_SCAN_HASHCNT_EN
    logic [63:0]  hash_count;
`endif

    keccak_nonce_scanner #(
        .CORE_LATENCY(L),
        .NONCE_WIDTH (NW),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .work_load  (work_load),
        .work_header(work_header),
        .start_nonce(start_nonce),
        .end_nonce  (end_nonce),
        .target     (target),
        .core_data  (core_data),
        .core_hash  (core_hash),
        .busy       (busy),
        .done       (done),
        .found_valid(found_valid),
        .found_ready(found_ready),
        .found_nonce(found_nonce),
`ifdef KECCAK_SCAN_HASHCNT_EN
        .hash_count (hash_count),
`endif
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in core: low hash word is zero only for nonce 0x2A.
    function automatic logic [63:0] core_fn(input logic [479:0] h, input logic [31:0] n);
        if (n == 32'h2A) return 64'd0;
        return {(n * 32'h9E3779B1) ^ h[31:0], h[63:32] + n} | 64'd1;
    endfunction

    logic [511:0] cpipe [L];
    always @(posedge clk) begin
        cpipe[0] <= {core_data[511:64] ^ {448{1'b1}}, core_fn(core_data[511:32], core_data[31:0])};
        for (int i = 1; i < L; i++) cpipe[i] <= cpipe[i-1];
    end
    assign core_hash = cpipe[L-1];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int          arr;
        logic [31:0] nonce;
    } pend_t;

    bit           m_on = 1'b0;
    bit           have_scan = 1'b0;
    bit           m_fresh = 1'b0;
    int           sc_c = 0;
    int unsigned  sc_n = 0;
    logic [31:0]  sc_s = '0;
    logic [479:0] sc_h = '0;
    logic [511:0] m_cd = '0;
    logic [31:0]  mfifo[$];
    pend_t        pend[$];
    int           cntq[$];
    int           m_drop = 0;
    longint       m_hc = 0;

    logic [31:0]  got[$];
    int           busy_cnt = 0;
    int           rise_cyc = -1;
    bit           prev_fv = 1'b0;

    always @(negedge clk) begin
        int          t;
        logic [31:0] nn;
        pend_t       p;
        if (m_on) begin
            chk("busy", busy, have_scan && cyc > sc_c && cyc <= sc_c + int'(sc_n) + L + 1);
            chk("done", done, have_scan && cyc > sc_c + int'(sc_n) + L + 1);
            chk("core_data", core_data, m_cd);
            chk("found_valid", found_valid, mfifo.size() != 0);
            if (mfifo.size() != 0) chk("found_nonce", found_nonce, mfifo[0]);
            else if (m_fresh) chk("found_nonce_rst", found_nonce, 32'd0);
            chk("drop_count", drop_count, m_drop);
`ifdef KECCAK_SCAN_HASHCNT_EN
            chk("hash_count", hash_count, m_hc);
`endif
            if (found_valid && found_ready) got.push_back(found_nonce);
            if (busy) busy_cnt++;
            if (found_valid && !prev_fv) rise_cyc = cyc;
            prev_fv = found_valid;
        end
        // Advance the reference to the next cycle using this cycle's inputs.
        if (reset) begin
            m_on = 1'b1; have_scan = 1'b0; m_cd = '0; m_fresh = 1'b1;
            mfifo.delete(); pend.delete(); cntq.delete();
            m_drop = 0; m_hc = 0;
        end else if (m_on) begin
            if (mfifo.size() != 0 && found_ready) void'(mfifo.pop_front());
            while (pend.size() != 0 && pend[0].arr <= cyc + 1) begin
                if (pend[0].arr == cyc + 1) begin
                    if (mfifo.size() < FD) begin
                        mfifo.push_back(pend[0].nonce);
                        m_fresh = 1'b0;
                    end else if (m_drop < 16'hFFFF) begin
                        m_drop++;
                    end
                end
                void'(pend.pop_front());
            end
            while (cntq.size() != 0 && cntq[0] <= cyc + 1) begin
                m_hc++;
                void'(cntq.pop_front());
            end
            if (work_load) begin
                while (pend.size() != 0 && pend[$].arr >= cyc + 3) void'(pend.pop_back());
                while (cntq.size() != 0 && cntq[$] >= cyc + 2) void'(cntq.pop_back());
                have_scan = 1'b1; sc_c = cyc; sc_s = start_nonce; sc_h = work_header;
                sc_n = (end_nonce - start_nonce) + 32'd1;
                for (int unsigned k = 0; k < sc_n; k++) begin
                    t  = cyc + 2 + int'(k);
                    nn = start_nonce + k;
                    cntq.push_back(t + L + 1);
                    if (core_fn(work_header, nn) <= target) begin
                        p.arr = t + L + 2;
                        p.nonce = nn;
                        pend.push_back(p);
                    end
                end
            end
            if (have_scan && cyc + 1 >= sc_c + 2 && cyc + 1 <= sc_c + int'(sc_n) + 1)
                m_cd = {sc_h, sc_s + 32'(cyc + 1 - sc_c - 2)};
        end
    end

    bit rr_en = 1'b0;
    logic [31:0] expq[$];

    task automatic step();
        @(posedge clk);
        #1;
        if (rr_en) found_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_load(input logic [31:0] s, input logic [31:0] e, input logic [63:0] tg, output int c);
        for (int i = 0; i < 15; i++) work_header[i*32 +: 32] = $urandom;
        start_nonce = s; end_nonce = e; target = tg;
        work_load = 1'b1; c = cyc;
        step();
        work_load = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string name);
        int k;
        k = 0;
        while (!done && k < limit) begin step(); k++; end
        if (!done) begin
            tests++; fails++;
            $display("FAIL %s: done=%0b after %0d cycles, required 1", name, done, limit);
        end
    endtask

    task automatic chk_got(input string name, input int base);
        chk({name, "_count"}, got.size() - base, expq.size());
        for (int i = 0; i < expq.size() && base + i < got.size(); i++)
            chk(name, got[base+i], expq[i]);
    endtask

    initial begin
        int c, c2, b0, g0;
        logic [31:0] s, e;
        logic [63:0] tg;

        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_found_valid", found_valid, 1'b0);
        chk("rst_core_data", core_data, 512'd0);
        chk("rst_drop", drop_count, 16'd0);

        // Plain range, ready always high.
        found_ready = 1'b1;
        b0 = busy_cnt; g0 = got.size();
        do_load(32'h10, 32'h13, '1, c);
        wait_done(300, "s1_done");
        repeat (6) step();
        expq.delete(); expq.push_back(32'h10); expq.push_back(32'h11);
        expq.push_back(32'h12); expq.push_back(32'h13);
        chk_got("s1_nonces", g0);
        chk("s1_first_latency", rise_cyc - c, L + 4);
        chk("s1_busy_cycles", busy_cnt - b0, 4 + L + 1);
        chk("s1_drop", drop_count, 16'd0);
`ifdef KECCAK_SCAN_HASHCNT_EN
        chk("s1_hash_count", hash_count, 64'd4);
`endif

        // Target 0: only 0x2A has a zero low hash word.
        g0 = got.size();
        do_load(32'h0, 32'hFF, 64'd0, c);
        wait_done(1000, "s2_done");
        repeat (6) step();
        expq.delete(); expq.push_back(32'h2A);
        chk_got("s2_single", g0);

        // Wrap through all-ones.
        g0 = got.size();
        do_load(32'hFFFFFFFE, 32'h1, '1, c);
        wait_done(300, "s3_done");
        repeat (6) step();
        expq.delete(); expq.push_back(32'hFFFFFFFE); expq.push_back(32'hFFFFFFFF);
        expq.push_back(32'h0); expq.push_back(32'h1);
        chk_got("s3_wrap", g0);

        // FIFO full with consumer stalled.
        found_ready = 1'b0;
        g0 = got.size();
        do_load(32'h0, 32'h9, '1, c);
        wait_done(300, "s4_done");
        repeat (6) step();
        chk("s4_drop", drop_count, 16'd6);
        chk("s4_head_valid", found_valid, 1'b1);
        chk("s4_head", found_nonce, 32'h0);
        found_ready = 1'b1;
        repeat (8) step();
        expq.delete();
        for (int i = 0; i < 4; i++) expq.push_back(32'(i));
        chk_got("s4_drain", g0);

        // Abort mid-scan.
        g0 = got.size();
        do_load(32'h0, 32'd99, '1, c);
        repeat (19) step();
        do_load(32'h500, 32'h501, '1, c2);
        wait_done(300, "s5_done");
        repeat (6) step();
        expq.delete(); expq.push_back(32'h500); expq.push_back(32'h501);
        chk_got("s5_abort", g0);

        // Randomised scans, targets, back-pressure and early aborts.
        rr_en = 1'b1;
        for (int it = 0; it < 16; it++) begin
            case ($urandom_range(0, 2))
                0: s = 32'hFFFFFFF8 + $urandom_range(0, 7);
                1: s = $urandom_range(32'h20, 32'h30);
                default: s = $urandom;
            endcase
            e = s + $urandom_range(0, 11);
            case ($urandom_range(0, 2))
                0: tg = '1;
                1: tg = 64'd0;
                default: tg = {$urandom, $urandom};
            endcase
            do_load(s, e, tg, c);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 30)) step();
                s = $urandom_range(32'h24, 32'h2A);
                do_load(s, s + $urandom_range(0, 5), {$urandom, $urandom}, c2);
            end
            wait_done(400, "rnd_done");
            repeat (8) step();
        end
        rr_en = 1'b0;
        found_ready = 1'b1;
        repeat (10) step();

        // Reset while draining.
        g0 = got.size();
        do_load(32'h0, 32'h7, '1, c);
        repeat (20) step();
        chk("rd_busy_before", busy, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rd_busy", busy, 1'b0);
        chk("rd_done", done, 1'b0);
        chk("rd_found_valid", found_valid, 1'b0);
        chk("rd_found_nonce", found_nonce, 32'd0);
        chk("rd_core_data", core_data, 512'd0);
        chk("rd_drop", drop_count, 16'd0);
`ifdef KECCAK_SCAN_HASHCNT_EN
        chk("rd_hash_count", hash_count, 64'd0);
`endif
        repeat (100) step();
        chk("rd_no_hits", got.size() - g0, 0);
        chk("rd_idle_found_valid", found_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
